data_bus_if: RTL and testbench

Data-side bus interface between the mem stage and the Wishbone data bus. It takes the mem stage's combinational memory request (address, write enable, big-endian byte selects, store data, chip enable) and turns it into a registered Wishbone classic cycle. It holds the pipeline with a stall request until the bus acknowledges, then returns the load data to the mem stage. A bus timeout keeps the core from hanging on an unmapped address.

---
 rtl/data_bus_if_pkg.sv | 24 ++
 rtl/data_bus_if_timeout.sv | 36 +++
 rtl/data_bus_if.sv | 126 ++++++++++++
 tb/tb_data_bus_if.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/data_bus_if_pkg.sv
// Shared definitions for the data-side Wishbone bus interface.
package data_bus_if_pkg;

    localparam int unsigned WB_ADDR_W       = 32;
    localparam int unsigned WB_DATA_W       = 32;
    localparam int unsigned WB_SEL_W        = 4;
    localparam int unsigned TO_CNT_W        = 8;
    localparam int unsigned TIMEOUT_DEFAULT = 255;

    typedef enum logic [1:0] {
        BUS_IDLE       = 2'd0,
        BUS_BUSY       = 2'd1,
        BUS_WAIT_STALL = 2'd2
    } bus_state_e;

    // Request payload held on the Wishbone master outputs for one bus cycle.
    typedef struct packed {
        logic [WB_ADDR_W-1:0] adr;
        logic [WB_DATA_W-1:0] dat;
        logic [WB_SEL_W-1:0]  sel;
        logic                 we;
    } wb_req_t;

endpackage

// File: rtl/data_bus_if_timeout.sv
// Ack timeout counter: counts ack-less bus cycles and flags when TIMEOUT is reached.
module bus_timeout_cnt
    import data_bus_if_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    logic [TO_CNT_W-1:0] cnt_q;
    logic [TO_CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + TO_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == TO_CNT_W'(TIMEOUT));

endmodule

// File: rtl/data_bus_if.sv
// Mem-stage to Wishbone classic bridge: one outstanding cycle, stalls the
// pipeline until ack or timeout, and parks load data while the pipeline is held.
module data_bus_if
    import data_bus_if_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_mem_ce,
    input  logic                 in_mem_we,
    input  logic [WB_ADDR_W-1:0] in_mem_addr,
    input  logic [WB_SEL_W-1:0]  in_mem_sel,
    input  logic [WB_DATA_W-1:0] in_mem_data,
    input  logic                 in_stall,
    input  logic                 in_flush,
    output logic [WB_DATA_W-1:0] out_mem_data,
    output logic                 out_stallreq,
    output logic                 out_bus_err,
    output logic [WB_ADDR_W-1:0] wb_adr_o,
    output logic [WB_DATA_W-1:0] wb_dat_o,
    output logic [WB_SEL_W-1:0]  wb_sel_o,
    output logic                 wb_we_o,
    output logic                 wb_cyc_o,
    output logic                 wb_stb_o,
    input  logic [WB_DATA_W-1:0] wb_dat_i,
    input  logic                 wb_ack_i
);

    bus_state_e           state_q, state_d;
    wb_req_t              req_q, req_d;
    logic                 cyc_q, cyc_d;
    logic [WB_DATA_W-1:0] buf_q, buf_d;
    logic                 cnt_clr, cnt_en, cnt_expired;

    bus_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (cnt_clr),
        .en_i      (cnt_en),
        .expired_o (cnt_expired)
    );

    // Next state, register updates and the combinational mem-stage outputs.
    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        cyc_d        = cyc_q;
        buf_d        = buf_q;
        cnt_clr      = 1'b0;
        cnt_en       = 1'b0;
        out_mem_data = '0;
        out_stallreq = 1'b0;
        out_bus_err  = 1'b0;

        if (!rst) begin
            unique case (state_q)
                BUS_IDLE: begin
                    if (in_mem_ce && !in_flush) begin
                        req_d        = '{adr: in_mem_addr, dat: in_mem_data,
                                         sel: in_mem_sel, we: in_mem_we};
                        cyc_d        = 1'b1;
                        cnt_clr      = 1'b1;
                        out_stallreq = 1'b1;
                        state_d      = BUS_BUSY;
                    end
                end
                BUS_BUSY: begin
                    if (in_flush || wb_ack_i || cnt_expired) begin
                        cyc_d     = 1'b0;
                        req_d.we  = 1'b0;
                        req_d.sel = '0;
                    end
                    // Flush abandons the cycle outright, even against ack/timeout.
                    if (in_flush) begin
                        state_d = BUS_IDLE;
                    end else if (wb_ack_i) begin
                        out_mem_data = wb_dat_i;
                        buf_d        = wb_dat_i;
                        state_d      = in_stall ? BUS_WAIT_STALL : BUS_IDLE;
                    end else if (cnt_expired) begin
                        out_bus_err = 1'b1;
                        buf_d       = '0;
                        state_d     = in_stall ? BUS_WAIT_STALL : BUS_IDLE;
                    end else begin
                        out_stallreq = 1'b1;
                        cnt_en       = 1'b1;
                    end
                end
                BUS_WAIT_STALL: begin
                    out_mem_data = buf_q;
                    if (!in_stall || in_flush) begin
                        state_d = BUS_IDLE;
                    end
                end
                default: begin
                    state_d = BUS_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= BUS_IDLE;
            req_q   <= '0;
            cyc_q   <= 1'b0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            cyc_q   <= cyc_d;
            buf_q   <= buf_d;
        end
    end

    assign wb_adr_o = req_q.adr;
    assign wb_dat_o = req_q.dat;
    assign wb_sel_o = req_q.sel;
    assign wb_we_o  = req_q.we;
    assign wb_cyc_o = cyc_q;
    assign wb_stb_o = cyc_q;

endmodule

// File: tb/tb_data_bus_if.sv
// Directed bench for data_bus_if with a cycle-level behavioural model checked every cycle.
module tb_data_bus_if;

    localparam int unsigned TO = 4;

    logic        clk;
    logic        rst;
    logic        ce, we, in_stall, in_flush, ack;
    logic [31:0] addr, data, wdat;
    logic [3:0]  sel;
    logic [31:0] out_mem_data, wb_adr_o, wb_dat_o;
    logic        out_stallreq, out_bus_err, wb_we_o, wb_cyc_o, wb_stb_o;
    logic [3:0]  wb_sel_o;

    int n_checks = 0;
    int n_fail   = 0;

    data_bus_if #(.TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_mem_ce    (ce),
        .in_mem_we    (we),
        .in_mem_addr  (addr),
        .in_mem_sel   (sel),
        .in_mem_data  (data),
        .in_stall     (in_stall),
        .in_flush     (in_flush),
        .out_mem_data (out_mem_data),
        .out_stallreq (out_stallreq),
        .out_bus_err  (out_bus_err),
        .wb_adr_o     (wb_adr_o),
        .wb_dat_o     (wb_dat_o),
        .wb_sel_o     (wb_sel_o),
        .wb_we_o      (wb_we_o),
        .wb_cyc_o     (wb_cyc_o),
        .wb_stb_o     (wb_stb_o),
        .wb_dat_i     (wdat),
        .wb_ack_i     (ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // Model: an open bus cycle with its age (1 = first cycle with cyc high),
    // a parked result awaiting stall release, and the last request latched.
    logic        m_active, m_hold, m_we;
    int          m_age;
    logic [31:0] m_adr, m_dat, m_buf;
    logic [3:0]  m_sel;
    logic [31:0] e_data;
    logic        e_stall, e_err;
    int          fin;

    initial begin : model
        forever begin
            @(negedge clk);
            e_data = '0; e_stall = 1'b0; e_err = 1'b0; fin = 0;
            if (rst) begin
                m_active = 1'b0; m_hold = 1'b0; m_age = 0; m_we = 1'b0;
                m_adr = '0; m_dat = '0; m_buf = '0; m_sel = '0;
            end else if (m_active) begin
                if (in_flush)          fin = 3;
                else if (ack)          fin = 1;
                else if (m_age == TO + 1) fin = 2;
                e_stall = (fin == 0);
                e_err   = (fin == 2);
                if (fin == 1) e_data = wdat;
            end else if (m_hold) begin
                e_data = m_buf;
            end else begin
                e_stall = ce & ~in_flush;
            end

            check("m_cyc",   32'(wb_cyc_o), 32'(m_active));
            check("m_stb",   32'(wb_stb_o), 32'(m_active));
            check("m_adr",   wb_adr_o, m_adr);
            check("m_dat",   wb_dat_o, m_dat);
            check("m_sel",   32'(wb_sel_o), m_active ? 32'(m_sel) : 32'd0);
            check("m_we",    32'(wb_we_o), 32'(m_active & m_we));
            check("m_data",  out_mem_data, e_data);
            check("m_stall", 32'(out_stallreq), 32'(e_stall));
            check("m_err",   32'(out_bus_err), 32'(e_err));

            if (!rst) begin
                if (m_active) begin
                    if (fin != 0) begin
                        m_active = 1'b0;
                        if (fin == 1) m_buf = wdat;
                        if (fin == 2) m_buf = '0;
                        if (fin != 3 && in_stall) m_hold = 1'b1;
                    end else begin
                        m_age++;
                    end
                end else if (m_hold) begin
                    if (!in_stall || in_flush) m_hold = 1'b0;
                end else if (ce && !in_flush) begin
                    m_active = 1'b1; m_age = 1;
                    m_adr = addr; m_dat = data; m_sel = sel; m_we = we;
                end
            end
        end
    end

    initial begin : stim
        rst = 1'b1;
        ce = 0; we = 0; in_stall = 0; in_flush = 0; ack = 0;
        addr = '0; data = '0; wdat = '0; sel = '0;
        mid();
        check("rst_cyc",   32'(wb_cyc_o), 32'd0);
        check("rst_stall", 32'(out_stallreq), 32'd0);
        tick(); tick();
        rst = 1'b0;

        // Zero-wait load
        tick(); ce = 1; we = 0; addr = 32'h100; sel = 4'hF;
        mid(); check("t1_stall_c0", 32'(out_stallreq), 32'd1);
        tick(); ack = 1; wdat = 32'hDEADBEEF;
        mid(); check("t1_data_c1", out_mem_data, 32'hDEADBEEF);
        check("t1_stall_c1", 32'(out_stallreq), 32'd0);
        check("t1_cyc_c1", 32'(wb_cyc_o), 32'd1);
        tick(); ack = 0; ce = 0;
        mid(); check("t1_cyc_c2", 32'(wb_cyc_o), 32'd0);

        // Byte store, 3 wait states
        tick(); ce = 1; we = 1; addr = 32'h203; sel = 4'b0001; data = 32'h5A5A5A5A;
        for (int i = 1; i <= 4; i++) begin
            tick(); ack = (i == 4); wdat = '0;
            mid();
            check("t2_sel", 32'(wb_sel_o), 32'd1);
            check("t2_we", 32'(wb_we_o), 32'd1);
            check("t2_dat", wb_dat_o, 32'h5A5A5A5A);
            check("t2_stall", 32'(out_stallreq), (i < 4) ? 32'd1 : 32'd0);
        end
        tick(); ack = 0; ce = 0; we = 0;
        mid(); check("t2_we_off", 32'(wb_we_o), 32'd0);
        check("t2_sel_off", 32'(wb_sel_o), 32'd0);

        // Ack while the pipeline is held
        tick(); ce = 1; we = 0; addr = 32'h300; sel = 4'hF; data = '0;
        tick(); ack = 1; wdat = 32'h12345678; in_stall = 1;
        mid(); check("t3_data_ack", out_mem_data, 32'h12345678);
        for (int i = 2; i <= 4; i++) begin
            tick(); ack = 0; wdat = 32'hFFFFFFFF;
            mid(); check("t3_data_hold", out_mem_data, 32'h12345678);
            check("t3_no_cyc", 32'(wb_cyc_o), 32'd0);
        end
        tick(); in_stall = 0;
        mid(); check("t3_data_rel", out_mem_data, 32'h12345678);
        tick(); ce = 0;
        mid(); check("t3_data_idle", out_mem_data, 32'd0);
        check("t3_cyc_idle", 32'(wb_cyc_o), 32'd0);

        // Timeout on a silent slave
        tick(); ce = 1; addr = 32'hFFFF0000; wdat = 32'hAAAAAAAA;
        for (int i = 1; i <= 5; i++) begin
            tick();
            mid();
            check("t4_err", 32'(out_bus_err), (i == 5) ? 32'd1 : 32'd0);
            check("t4_stall", 32'(out_stallreq), (i < 5) ? 32'd1 : 32'd0);
            check("t4_cyc", 32'(wb_cyc_o), 32'd1);
            if (i == 5) check("t4_data", out_mem_data, 32'd0);
        end
        tick(); ce = 0;
        mid(); check("t4_cyc_off", 32'(wb_cyc_o), 32'd0);
        check("t4_err_off", 32'(out_bus_err), 32'd0);

        // Flush colliding with ack in the second busy cycle
        tick(); ce = 1; addr = 32'h500;
        tick();
        mid(); check("t5_stall_c1", 32'(out_stallreq), 32'd1);
        tick(); in_flush = 1; ack = 1; wdat = 32'h11111111; in_stall = 1;
        mid(); check("t5_stall", 32'(out_stallreq), 32'd0);
        check("t5_err", 32'(out_bus_err), 32'd0);
        check("t5_data", out_mem_data, 32'd0);
        tick(); in_flush = 0; ack = 0; ce = 0;
        mid(); check("t5_cyc", 32'(wb_cyc_o), 32'd0);
        check("t5_idle_data", out_mem_data, 32'd0);
        tick(); in_stall = 0;

        // Asynchronous reset in the middle of a bus cycle
        tick(); ce = 1; we = 1; addr = 32'h380; sel = 4'hC; data = 32'hA5A5A5A5;
        tick();
        check("t6_adr_pre", wb_adr_o, 32'h380);
        #2 rst = 1'b1;
        #1;
        check("t6_cyc", 32'(wb_cyc_o), 32'd0);
        check("t6_stb", 32'(wb_stb_o), 32'd0);
        check("t6_adr", wb_adr_o, 32'd0);
        check("t6_dat", wb_dat_o, 32'd0);
        check("t6_sel", 32'(wb_sel_o), 32'd0);
        check("t6_we", 32'(wb_we_o), 32'd0);
        mid(); check("t6_stall_rst", 32'(out_stallreq), 32'd0);
        tick(); rst = 1'b0; ce = 0; we = 0;
        tick(); ce = 1; addr = 32'h400; sel = 4'hF; data = '0;
        tick();
        mid(); check("t6_stall_new", 32'(out_stallreq), 32'd1);
        check("t6_adr_new", wb_adr_o, 32'h400);
        tick(); ack = 1; wdat = 32'h0BADCAFE;
        mid(); check("t6_data_new", out_mem_data, 32'h0BADCAFE);
        tick(); ack = 0; ce = 0;
        mid(); check("t6_cyc_new", 32'(wb_cyc_o), 32'd0);

        tick(); tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
